axi_ram_rd_arbiter: RTL and testbench
=====================================

Name: axi_ram_rd_arbiter

Overview:
Shares one RAM read command/response port between PORTS RAM read requesters, each an AXI RAM read interface front end. Whole command bursts are granted round-robin, and the grant is held from the first beat through the beat flagged last. The RAM returns responses in order, so a route FIFO of granted port indices steers each response burst back to its requester.

Parameters:
PORTS, 2, number of requesters (>=2)
DATA_WIDTH, 32, RAM data width
ADDR_WIDTH, 16, byte address width
ID_WIDTH, 8, transaction ID width
ARUSER_WIDTH, 1, command user width
RUSER_WIDTH, 1, response user width
FIFO_DEPTH, 4, max bursts granted but not fully responded (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_ram_rd_cmd_id  in  PORTS*ID_WIDTH  per-port command ID
s_ram_rd_cmd_addr  in  PORTS*ADDR_WIDTH  per-port beat address
s_ram_rd_cmd_auser  in  PORTS*ARUSER_WIDTH  per-port user
s_ram_rd_cmd_en  in  PORTS  per-port command valid
s_ram_rd_cmd_last  in  PORTS  per-port last beat of burst
s_ram_rd_cmd_ready  out  PORTS  per-port command ready
s_ram_rd_resp_id  out  PORTS*ID_WIDTH  response ID (broadcast)
s_ram_rd_resp_data  out  PORTS*DATA_WIDTH  response data (broadcast)
s_ram_rd_resp_last  out  PORTS  response last (broadcast)
s_ram_rd_resp_user  out  PORTS*RUSER_WIDTH  response user (broadcast)
s_ram_rd_resp_valid  out  PORTS  per-port response valid
s_ram_rd_resp_ready  in  PORTS  per-port response ready
m_ram_rd_cmd_id/addr/auser  out  ID_WIDTH/ADDR_WIDTH/ARUSER_WIDTH  granted command fields
m_ram_rd_cmd_en  out  1  command valid
m_ram_rd_cmd_last  out  1  last beat
m_ram_rd_cmd_ready  in  1  RAM accepts beat
m_ram_rd_resp_id/data/user  in  ID_WIDTH/DATA_WIDTH/RUSER_WIDTH  RAM response fields
m_ram_rd_resp_last  in  1  last response beat
m_ram_rd_resp_valid  in  1  response valid
m_ram_rd_resp_ready  out  1  response ready

Behaviour:
- Reset (rst_n low, async): state IDLE; route FIFO empty; last_grant = PORTS-1, so port 0 has top priority first. All outputs are derived combinationally from this state, which gives m_ram_rd_cmd_en=0, s_ram_rd_cmd_ready=0, s_ram_rd_resp_valid=0 and m_ram_rd_resp_ready=0.
- IDLE state:
  - No port is connected: m_cmd_en=0 and all s_cmd_ready=0.
  - If any s_cmd_en is set and the FIFO is not full, pick the first requesting port scanning from last_grant+1 mod PORTS upward with wrap.
  - On a pick: grant_reg<=port, last_grant<=port, push port into the FIFO, next state BURST.
  - FIFO full: no grant; requests are held.
- BURST state:
  - Mux: m_cmd_* = s_cmd_*[grant_reg]; m_cmd_en = s_cmd_en[grant_reg]; s_cmd_ready[grant_reg] = m_cmd_ready; other ready bits are 0.
  - Beat accepted (en&&ready) with last=1: next state IDLE.
  - Otherwise stay in BURST, including requester gaps with en=0 mid-burst.
  - No re-arbitration until last is accepted.
- Bubble: exactly one IDLE cycle between consecutive bursts. A 1-beat request on an idle arbiter reaches m_cmd_en on the cycle after s_cmd_en is asserted.
- Response routing, head = FIFO head port:
  - Response fields are broadcast to every port.
  - s_resp_valid[head] = m_resp_valid && !empty; other valid bits are 0.
  - m_resp_ready = !empty && s_resp_ready[head].
  - Pop on m_resp_valid && m_resp_ready && m_resp_last.
  - Responses may start before the burst's command last beat; the entry is already in the FIFO at grant.
- Simultaneous push (grant) and pop in the same cycle: count is unchanged, both take effect.
- Pointers: log2(FIFO_DEPTH)-bit read/write pointers wrap naturally. Count is $clog2(FIFO_DEPTH+1) bits. Full when count==FIFO_DEPTH.
- m_resp_valid while empty is a protocol error: it is ignored and never forwarded.
- Reset mid-burst: state, grant and FIFO clear immediately. Any in-flight responses are dropped by the empty-FIFO rule.
- Elaboration: $error/$finish if PORTS<2 or FIFO_DEPTH is not a power of two >=2.

Test Plan:
1. Port 0 single beat, addr=0x0040, id=5, last=1.
   -> m_cmd_en asserts the cycle after s_cmd_en[0] with addr 0x0040, id 5.
   -> The RAM response (data=0xDEADBEEF, last) appears only on s_resp_valid[0].
2. Ports 0 and 1 both request 1-beat bursts continuously.
   -> Grants go 0,1,0,1 with one bubble each; 4 bursts are accepted in 8 cycles.
3. Port 1 4-beat burst (addrs 0x0,0x4,0x8,0xC, last on 4th) with port 0 requesting throughout.
   -> All four port-1 beats are issued contiguously before port 0 is granted.
   -> m_cmd_ready toggling 1,0,1 never causes a grant change.
4. FIFO_DEPTH=2; s_resp_ready all 0; ports issue three 1-beat bursts.
   -> The third grant is withheld until the first response's last beat pops (s_resp_ready[head]=1), then it is granted.
5. Overlap: port 0 2-beat burst, its first response returns before the second command beat.
   -> The response is routed to port 0, and the pop happens only on the response beat with last=1.
6. Assert rst_n=0 mid-burst after beat 2 of 4.
   -> m_cmd_en=0, all s_cmd_ready=0 and all s_resp_valid=0 immediately (async).
   -> After release, port 0 is granted first.

Source files
------------

// File: rtl/axi_ram_rd_arbiter.sv
// Round-robin burst arbiter sharing one RAM read command/response port between
// PORTS requesters; an in-order route FIFO steers response bursts back home.

module axi_ram_rd_arbiter_lane #(
  parameter int PW  = 1,
  parameter int IDX = 0
) (
  input  logic          burst,
  input  logic [PW-1:0] grant,
  input  logic [PW-1:0] head,
  input  logic          fifo_empty,
  input  logic          m_cmd_ready,
  input  logic          m_resp_valid,
  output logic          cmd_ready,
  output logic          resp_valid
);
  assign cmd_ready  = burst && (grant == PW'(IDX)) && m_cmd_ready;
  assign resp_valid = m_resp_valid && !fifo_empty && (head == PW'(IDX));
endmodule

module axi_ram_rd_arbiter #(
  parameter int PORTS        = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 8,
  parameter int ARUSER_WIDTH = 1,
  parameter int RUSER_WIDTH  = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PORTS*ID_WIDTH-1:0]       s_ram_rd_cmd_id,
  input  logic [PORTS*ADDR_WIDTH-1:0]     s_ram_rd_cmd_addr,
  input  logic [PORTS*ARUSER_WIDTH-1:0]   s_ram_rd_cmd_auser,
  input  logic [PORTS-1:0]                s_ram_rd_cmd_en,
  input  logic [PORTS-1:0]                s_ram_rd_cmd_last,
  output logic [PORTS-1:0]                s_ram_rd_cmd_ready,
  output logic [PORTS*ID_WIDTH-1:0]       s_ram_rd_resp_id,
  output logic [PORTS*DATA_WIDTH-1:0]     s_ram_rd_resp_data,
  output logic [PORTS-1:0]                s_ram_rd_resp_last,
  output logic [PORTS*RUSER_WIDTH-1:0]    s_ram_rd_resp_user,
  output logic [PORTS-1:0]                s_ram_rd_resp_valid,
  input  logic [PORTS-1:0]                s_ram_rd_resp_ready,
  output logic [ID_WIDTH-1:0]             m_ram_rd_cmd_id,
  output logic [ADDR_WIDTH-1:0]           m_ram_rd_cmd_addr,
  output logic [ARUSER_WIDTH-1:0]         m_ram_rd_cmd_auser,
  output logic                            m_ram_rd_cmd_en,
  output logic                            m_ram_rd_cmd_last,
  input  logic                            m_ram_rd_cmd_ready,
  input  logic [ID_WIDTH-1:0]             m_ram_rd_resp_id,
  input  logic [DATA_WIDTH-1:0]           m_ram_rd_resp_data,
  input  logic [RUSER_WIDTH-1:0]          m_ram_rd_resp_user,
  input  logic                            m_ram_rd_resp_last,
  input  logic                            m_ram_rd_resp_valid,
  output logic                            m_ram_rd_resp_ready
);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  generate
    if (PORTS < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("axi_ram_rd_arbiter: need PORTS>=2 and FIFO_DEPTH a power of two >=2");
    end
  endgenerate

  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nxt;

  logic [PW-1:0] grant_reg, last_grant, pick, cand, head;
  logic          pick_vld, push, pop, empty, full;
  logic [PW-1:0] route_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign head  = route_mem[rd_ptr];
  assign push  = (state == IDLE) && pick_vld && !full;
  assign pop   = m_ram_rd_resp_valid && m_ram_rd_resp_ready && m_ram_rd_resp_last;

  // first requester after the last grant, with wrap
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int i = 1; i <= PORTS; i++) begin
      cand = PW'((int'(last_grant) + i) % PORTS);
      if (!pick_vld && s_ram_rd_cmd_en[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = BURST;
      BURST:   if (m_ram_rd_cmd_en && m_ram_rd_cmd_ready && m_ram_rd_cmd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_reg  <= '0;
      last_grant <= PW'(PORTS - 1);
    end else if (push) begin
      grant_reg  <= pick;
      last_grant <= pick;
    end
  end

  // route FIFO: entry pushed at grant, so responses may overtake the command tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) route_mem[wr_ptr] <= pick;
  end

  assign m_ram_rd_cmd_id     = s_ram_rd_cmd_id[grant_reg*ID_WIDTH +: ID_WIDTH];
  assign m_ram_rd_cmd_addr   = s_ram_rd_cmd_addr[grant_reg*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_ram_rd_cmd_auser  = s_ram_rd_cmd_auser[grant_reg*ARUSER_WIDTH +: ARUSER_WIDTH];
  assign m_ram_rd_cmd_last   = s_ram_rd_cmd_last[grant_reg];
  assign m_ram_rd_cmd_en     = (state == BURST) && s_ram_rd_cmd_en[grant_reg];
  assign m_ram_rd_resp_ready = !empty && s_ram_rd_resp_ready[head];

  assign s_ram_rd_resp_id   = {PORTS{m_ram_rd_resp_id}};
  assign s_ram_rd_resp_data = {PORTS{m_ram_rd_resp_data}};
  assign s_ram_rd_resp_last = {PORTS{m_ram_rd_resp_last}};
  assign s_ram_rd_resp_user = {PORTS{m_ram_rd_resp_user}};

  generate
    for (genvar p = 0; p < PORTS; p++) begin : g_lane
      axi_ram_rd_arbiter_lane #(.PW(PW), .IDX(p)) u_lane (
        .burst        (state == BURST),
        .grant        (grant_reg),
        .head         (head),
        .fifo_empty   (empty),
        .m_cmd_ready  (m_ram_rd_cmd_ready),
        .m_resp_valid (m_ram_rd_resp_valid),
        .cmd_ready    (s_ram_rd_cmd_ready[p]),
        .resp_valid   (s_ram_rd_resp_valid[p])
      );
    end
  endgenerate
endmodule

// File: tb/tb_axi_ram_rd_arbiter.sv
// Directed bench for axi_ram_rd_arbiter (PORTS=2, FIFO_DEPTH=2): expected command
// beats and routed responses are queued by stimulus and checked by a monitor.

module tb_axi_ram_rd_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  c_id   [2];
  logic [15:0] c_addr [2];
  logic [1:0]  c_en, c_last, s_rdy;
  logic [15:0] s_cmd_id;
  logic [31:0] s_cmd_addr;
  logic [1:0]  s_cmd_auser, s_cmd_ready;
  logic [15:0] s_resp_id;
  logic [63:0] s_resp_data;
  logic [1:0]  s_resp_last, s_resp_user, s_resp_valid;
  logic [7:0]  m_cmd_id;
  logic [15:0] m_cmd_addr;
  logic        m_cmd_auser, m_cmd_en, m_cmd_last, m_cmd_ready;
  logic [7:0]  r_id;
  logic [31:0] r_data;
  logic        r_last, r_valid, m_resp_ready;

  assign s_cmd_id    = {c_id[1], c_id[0]};
  assign s_cmd_addr  = {c_addr[1], c_addr[0]};
  assign s_cmd_auser = 2'b10;

  axi_ram_rd_arbiter #(.PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8),
                       .ARUSER_WIDTH(1), .RUSER_WIDTH(1), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_ram_rd_cmd_id(s_cmd_id), .s_ram_rd_cmd_addr(s_cmd_addr), .s_ram_rd_cmd_auser(s_cmd_auser),
    .s_ram_rd_cmd_en(c_en), .s_ram_rd_cmd_last(c_last), .s_ram_rd_cmd_ready(s_cmd_ready),
    .s_ram_rd_resp_id(s_resp_id), .s_ram_rd_resp_data(s_resp_data), .s_ram_rd_resp_last(s_resp_last),
    .s_ram_rd_resp_user(s_resp_user), .s_ram_rd_resp_valid(s_resp_valid), .s_ram_rd_resp_ready(s_rdy),
    .m_ram_rd_cmd_id(m_cmd_id), .m_ram_rd_cmd_addr(m_cmd_addr), .m_ram_rd_cmd_auser(m_cmd_auser),
    .m_ram_rd_cmd_en(m_cmd_en), .m_ram_rd_cmd_last(m_cmd_last), .m_ram_rd_cmd_ready(m_cmd_ready),
    .m_ram_rd_resp_id(r_id), .m_ram_rd_resp_data(r_data), .m_ram_rd_resp_user(1'b0),
    .m_ram_rd_resp_last(r_last), .m_ram_rd_resp_valid(r_valid), .m_ram_rd_resp_ready(m_resp_ready)
  );

  typedef struct packed { logic [7:0] id; logic [15:0] addr; logic last; } cmd_t;
  typedef struct packed { logic port; logic [7:0] id; logic [31:0] data; logic last; } resp_t;
  cmd_t  cmd_q [$];
  resp_t resp_q[$];
  int compared = 0, mismatched = 0, accepts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic exp_cmd(input logic [7:0] id, input logic [15:0] addr, input logic last);
    cmd_q.push_back('{id: id, addr: addr, last: last});
  endtask

  task automatic exp_resp(input logic port, input logic [7:0] id, input logic [31:0] data, input logic last);
    resp_q.push_back('{port: port, id: id, data: data, last: last});
  endtask

  task automatic mon_step();
    cmd_t c; resp_t r, g;
    if (!rst_n) return;
    if (m_cmd_en && m_cmd_ready) begin
      accepts++;
      if (cmd_q.size() == 0) tmo("cmd_unexpected_beat");
      else begin
        c = cmd_q.pop_front();
        check("cmd_beat", {m_cmd_id, m_cmd_addr, m_cmd_last}, c);
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (s_resp_valid[p] && s_rdy[p]) begin
        g = '{port: p[0], id: s_resp_id[p*8 +: 8], data: s_resp_data[p*32 +: 32], last: s_resp_last[p]};
        if (resp_q.size() == 0) tmo("resp_unexpected_beat");
        else begin
          r = resp_q.pop_front();
          check("resp_route", g, r);
        end
      end
    end
  endtask

  task automatic send_burst(input int p, input logic [7:0] id, input logic [15:0] base,
                            input int n, input int total);
    int t;
    for (int b = 0; b < n; b++) begin
      t = 0;
      c_id[p] = id; c_addr[p] = base + 16'(4 * b); c_last[p] = (b == total - 1); c_en[p] = 1'b1;
      forever begin
        @(negedge clk);
        if (s_cmd_ready[p]) break;
        if (++t > 60) begin tmo($sformatf("send_burst_p%0d", p)); break; end
      end
      @(posedge clk); #1;
    end
    c_en[p] = 1'b0;
    c_last[p] = 1'b0;
  endtask

  task automatic ram_resp(input logic [31:0] d, input logic [7:0] id, input logic l);
    int t;
    t = 0;
    r_data = d; r_id = id; r_last = l; r_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (m_resp_ready) break;
      if (++t > 60) begin tmo("ram_resp"); break; end
    end
    @(posedge clk); #1;
    r_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; c_en = '0; c_last = '0; s_rdy = 2'b11; m_cmd_ready = 1'b1;
    r_valid = 1'b1; r_last = 1'b1; r_id = 8'h0; r_data = 32'h0;
    for (int p = 0; p < 2; p++) begin c_id[p] = '0; c_addr[p] = '0; end
    fork forever begin @(negedge clk); mon_step(); end join_none

    // reset state; a stray response with an empty route FIFO is never forwarded
    #1;
    check("rst_m_cmd_en", m_cmd_en, 0);
    check("rst_s_cmd_ready", s_cmd_ready, 0);
    check("rst_s_resp_valid", s_resp_valid, 0);
    check("rst_m_resp_ready", m_resp_ready, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("empty_s_resp_valid", s_resp_valid, 0);
    check("empty_m_resp_ready", m_resp_ready, 0);
    @(posedge clk); #1 r_valid = 1'b0;

    // 1: single beat, one-cycle latency, response to port 0 only
    exp_cmd(8'h05, 16'h0040, 1'b1);
    fork
      send_burst(0, 8'h05, 16'h0040, 1, 1);
      begin
        @(negedge clk); check("t1_en_same_cycle", m_cmd_en, 0);
        @(negedge clk); check("t1_en_next_cycle", m_cmd_en, 1);
        check("t1_addr_id", {m_cmd_addr, m_cmd_id}, {16'h0040, 8'h05});
      end
    join
    exp_resp(1'b0, 8'h05, 32'hDEADBEEF, 1'b1);
    fork
      ram_resp(32'hDEADBEEF, 8'h05, 1'b1);
      begin @(negedge clk); check("t1_resp_onehot", s_resp_valid, 2'b01); end
    join

    // 2: both ports stream 1-beat bursts from reset priority: 0,1,0,1 in 8 cycles
    reset_dut();
    exp_cmd(8'h10, 16'h0010, 1'b1); exp_cmd(8'h20, 16'h0020, 1'b1);
    exp_cmd(8'h11, 16'h0010, 1'b1); exp_cmd(8'h21, 16'h0020, 1'b1);
    exp_resp(1'b0, 8'h10, 32'hA0000001, 1'b1); exp_resp(1'b1, 8'h20, 32'hA0000002, 1'b1);
    exp_resp(1'b0, 8'h11, 32'hA0000003, 1'b1); exp_resp(1'b1, 8'h21, 32'hA0000004, 1'b1);
    fork
      begin send_burst(0, 8'h10, 16'h0010, 1, 1); send_burst(0, 8'h11, 16'h0010, 1, 1); end
      begin send_burst(1, 8'h20, 16'h0020, 1, 1); send_burst(1, 8'h21, 16'h0020, 1, 1); end
      begin
        ram_resp(32'hA0000001, 8'h10, 1'b1); ram_resp(32'hA0000002, 8'h20, 1'b1);
        ram_resp(32'hA0000003, 8'h11, 1'b1); ram_resp(32'hA0000004, 8'h21, 1'b1);
      end
      begin
        int c0;
        c0 = accepts;
        repeat (8) @(posedge clk);
        @(negedge clk); check("t2_4_bursts_in_8", accepts - c0, 4);
      end
    join

    // 3: port 1 4-beat burst holds grant through a ready stall; port 0 waits
    exp_cmd(8'h30, 16'h0000, 1'b0); exp_cmd(8'h30, 16'h0004, 1'b0);
    exp_cmd(8'h30, 16'h0008, 1'b0); exp_cmd(8'h30, 16'h000C, 1'b1);
    exp_cmd(8'h31, 16'h0050, 1'b1);
    fork
      send_burst(1, 8'h30, 16'h0000, 4, 4);
      begin @(posedge clk); #1; send_burst(0, 8'h31, 16'h0050, 1, 1); end
      begin
        repeat (2) @(posedge clk); #1 m_cmd_ready = 1'b0;
        @(negedge clk);
        check("t3_stall_hold", {m_cmd_en, m_cmd_id, m_cmd_addr}, {1'b1, 8'h30, 16'h0004});
        check("t3_stall_ready", s_cmd_ready, 0);
        @(posedge clk); #1 m_cmd_ready = 1'b1;
      end
    join
    for (int k = 0; k < 4; k++) exp_resp(1'b1, 8'h30, 32'hB0 + k, k == 3);
    exp_resp(1'b0, 8'h31, 32'hB1000000, 1'b1);
    for (int k = 0; k < 4; k++) ram_resp(32'hB0 + k, 8'h30, k == 3);
    ram_resp(32'hB1000000, 8'h31, 1'b1);

    // 4: route FIFO full (depth 2) withholds the third grant until a pop
    s_rdy = 2'b00;
    exp_cmd(8'h41, 16'h0100, 1'b1); exp_cmd(8'h40, 16'h0200, 1'b1); exp_cmd(8'h42, 16'h0204, 1'b1);
    exp_resp(1'b1, 8'h41, 32'hC0000001, 1'b1);
    exp_resp(1'b0, 8'h40, 32'hC0000002, 1'b1);
    exp_resp(1'b0, 8'h42, 32'hC0000003, 1'b1);
    fork
      send_burst(1, 8'h41, 16'h0100, 1, 1);
      begin send_burst(0, 8'h40, 16'h0200, 1, 1); send_burst(0, 8'h42, 16'h0204, 1, 1); end
      begin
        repeat (6) @(negedge clk);
        check("t4_full_no_grant", m_cmd_en, 0);
        check("t4_full_no_ready", s_cmd_ready, 0);
        check("t4_resp_blocked", m_resp_ready, 0);
        @(posedge clk); #1 s_rdy = 2'b11;
        ram_resp(32'hC0000001, 8'h41, 1'b1);
        @(negedge clk); check("t4_no_grant_pop_edge", m_cmd_en, 0);
        @(negedge clk); check("t4_grant_after_pop", {m_cmd_en, m_cmd_id}, {1'b1, 8'h42});
      end
    join
    ram_resp(32'hC0000002, 8'h40, 1'b1);
    ram_resp(32'hC0000003, 8'h42, 1'b1);

    // 5: responses overtake the command tail; pop only on the last response beat
    exp_cmd(8'h50, 16'h0300, 1'b0); exp_cmd(8'h50, 16'h0304, 1'b1);
    exp_resp(1'b0, 8'h50, 32'hD0000001, 1'b0);
    exp_resp(1'b0, 8'h50, 32'hD0000002, 1'b1);
    fork
      send_burst(0, 8'h50, 16'h0300, 2, 2);
      begin
        repeat (2) @(posedge clk); #1 m_cmd_ready = 1'b0;
        ram_resp(32'hD0000001, 8'h50, 1'b0);
        ram_resp(32'hD0000002, 8'h50, 1'b1);
        r_valid = 1'b1; r_last = 1'b1;
        @(negedge clk);
        check("t5_popped_valid", s_resp_valid, 0);
        check("t5_popped_ready", m_resp_ready, 0);
        @(posedge clk); #1 r_valid = 1'b0; m_cmd_ready = 1'b1;
      end
    join

    // 6: async reset after beat 2 of 4; then reset priority favours port 0
    exp_cmd(8'h60, 16'h0400, 1'b0); exp_cmd(8'h60, 16'h0404, 1'b0);
    send_burst(0, 8'h60, 16'h0400, 2, 4);
    c_id[0] = 8'h60; c_addr[0] = 16'h0408; c_last[0] = 1'b0; c_en[0] = 1'b1;
    r_data = 32'hE0000000; r_id = 8'h60; r_last = 1'b1; r_valid = 1'b1;
    #1;
    check("t6_pre_cmd_en", m_cmd_en, 1);
    check("t6_pre_resp_valid", s_resp_valid, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_cmd_en", m_cmd_en, 0);
    check("t6_rst_cmd_ready", s_cmd_ready, 0);
    check("t6_rst_resp_valid", s_resp_valid, 0);
    check("t6_rst_resp_ready", m_resp_ready, 0);
    c_en = '0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    exp_cmd(8'h61, 16'h0500, 1'b1); exp_cmd(8'h62, 16'h0600, 1'b1);
    fork
      send_burst(0, 8'h61, 16'h0500, 1, 1);
      send_burst(1, 8'h62, 16'h0600, 1, 1);
      begin
        @(negedge clk);
        check("t6_drop_inflight", {s_resp_valid, m_resp_ready, m_cmd_en}, 0);
        r_valid = 1'b0;
        @(negedge clk);
        check("t6_port0_first", {m_cmd_en, m_cmd_id}, {1'b1, 8'h61});
      end
    join
    exp_resp(1'b0, 8'h61, 32'hE0000001, 1'b1);
    exp_resp(1'b1, 8'h62, 32'hE0000002, 1'b1);
    ram_resp(32'hE0000001, 8'h61, 1'b1);
    ram_resp(32'hE0000002, 8'h62, 1'b1);

    repeat (3) @(negedge clk);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
